// File: rtl/mux_rr_stream.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_stream
//  Purpose  : N-channel valid/ready stream multiplexer with one registered
//             output stage. One input channel is selected each cycle by a
//             run-time selectable arbiter (round-robin or fixed priority) and
//             its word is captured into the output register.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1             rising-edge clock
//    rst_n      in   1             asynchronous active-low reset
//    mode       in   1             0 = round-robin, 1 = fixed priority
//    in_data    in   NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//    in_valid   in   NUM_CH        per-channel valid
//    in_ready   out  NUM_CH        per-channel ready (combinational, one-hot)
//    out_data   out  WIDTH         registered data
//    out_valid  out  1             registered valid
//    out_ready  in   1             downstream ready
//    out_sel    out  SEL_W         registered source channel of out_data
// ============================================================================
module mux_rr_stream #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  localparam logic [SEL_W:0]   c_NUM_CH = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] c_LAST   = SEL_W'(NUM_CH - 1);

  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_out_sel;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load;
  logic              w_any;
  logic              w_xfer;
  logic              w_found;
  logic [SEL_W:0]    w_scan;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic [WIDTH-1:0]  w_ch_data [NUM_CH];

  // Split the flat input bus into per-channel words.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign w_ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The register can take a word when empty or when it is drained this cycle.
  assign w_load = ~r_out_valid | out_ready;
  assign w_any  = |in_valid;
  assign w_xfer = w_load & w_any;

  // Arbiter: scan channels starting at ptr (round-robin) or at 0 (fixed
  // priority) and grant the first valid one. The scan index is one bit wider
  // than a channel index so ptr+k can be folded back into range.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mode) begin
        w_scan = (SEL_W+1)'(k);
      end else begin
        w_scan = {1'b0, r_ptr} + (SEL_W+1)'(k);
        if (w_scan >= c_NUM_CH) begin
          w_scan = w_scan - c_NUM_CH;
        end
      end
      if (!w_found && in_valid[w_scan[SEL_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_gnt_oh[i] = w_found && (w_gnt_idx == SEL_W'(i));
    end
  end

  // Ready is forced low while reset is asserted so no handshake can complete
  // in a cycle whose state is being discarded.
  assign in_ready = (rst_n && w_xfer) ? w_gnt_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_ch_data[w_gnt_idx];
        r_out_sel  <= w_gnt_idx;
        // Pointer moves past the winner only in round-robin mode.
        if (!mode) begin
          r_ptr <= (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + 1'b1;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_stream
//  Purpose  : Self-checking bench for mux_rr_stream (WIDTH=8, NUM_CH=4).
//             Directed scenarios plus randomized traffic compared against a
//             behavioural model of the arbiter and output register.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_stream;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_sel;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_ptr;

  mux_rr_stream #(.WIDTH(WIDTH), .NUM_CH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which channel should win, from the arbitration rules: scan order starts
  // at ptr in round-robin mode, at 0 in fixed-priority mode. -1 = none.
  function automatic int exp_grant(logic [NCH-1:0] v, logic md, int p);
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = md ? k : (p + k) % NCH;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_ready();
    int g;
    g = exp_grant(in_valid, mode, m_ptr);
    if (rst_n && (!m_valid || out_ready) && g >= 0) return 4'b0001 << g;
    return '0;
  endfunction

  function automatic logic [WIDTH-1:0] ch_word(int c, logic [WIDTH-1:0] base);
    return base + WIDTH'(c);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then
  // move to the next falling edge where outputs are stable.
  task automatic tick();
    int g;
    if (!rst_n) begin
      model_reset();
    end else if (!m_valid || out_ready) begin
      g = exp_grant(in_valid, mode, m_ptr);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_sel   = g;
        if (!mode) m_ptr = (g + 1) % NCH;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_data(logic [WIDTH-1:0] base);
    for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = ch_word(c, base);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; in_valid = '0; out_ready = 1'b1; in_data = '0;
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      in_valid = (c == 1) ? 4'b1111 : 4'b0000;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_errors++; $display("FAIL reset_ready cyc=%0d got %b exp 0000", c, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
        n_errors++;
        $display("FAIL reset_out cyc=%0d got v=%b d=%h s=%0d exp v=0 d=00 s=0",
                 c, out_valid, out_data, out_sel);
      end
    end
    rst_n = 1'b1; in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_errors++; $display("FAIL idle_ready cyc=%0d got %b exp 0000", c, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
        n_errors++;
        $display("FAIL idle_out cyc=%0d got v=%b d=%h s=%0d exp v=0 d=00 s=0",
                 c, out_valid, out_data, out_sel);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_rr_fairness();
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; set_data(8'hA0);
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if ($countones(in_ready) != 1 || in_ready !== exp_ready()) begin
        n_errors++; $display("FAIL rr_ready cyc=%0d got %b exp %b", c, in_ready, exp_ready());
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(c % 4) || out_data !== 8'hA0 + 8'(c % 4)) begin
        n_errors++;
        $display("FAIL rr_out cyc=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                 c, out_valid, out_sel, out_data, c % 4, 8'hA0 + 8'(c % 4));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fixed_priority();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0110; set_data(8'h30);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin
        n_errors++; $display("FAIL fp_ready cyc=%0d got %b exp 0010", c, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h31) begin
        n_errors++;
        $display("FAIL fp_out cyc=%0d got v=%b s=%0d d=%h exp v=1 s=1 d=31",
                 c, out_valid, out_sel, out_data);
      end
    end
    in_valid = 4'b0100;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_errors++; $display("FAIL fp_drop_ready got %b exp 0100", in_ready);
    end
    tick();
    n_checks++;
    if (out_sel !== 2'd2 || out_data !== 8'h32) begin
      n_errors++; $display("FAIL fp_drop_out got s=%0d d=%h exp s=2 d=32", out_sel, out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
    in_data = '0; in_data[2*WIDTH +: WIDTH] = 8'h55;
    tick();
    out_ready = 1'b0; in_valid = 4'b1111;
    in_data = {8'h66, 8'h66, 8'h66, 8'h10};
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_errors++; $display("FAIL bp_ready cyc=%0d got %b exp 0000", c, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || out_sel !== 2'd2) begin
        n_errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h s=%0d exp v=1 d=55 s=2",
                 c, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_errors++; $display("FAIL bp_release_ready got %b exp 0001", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h10 || out_sel !== 2'd0) begin
      n_errors++;
      $display("FAIL bp_release_out got v=%b d=%h s=%0d exp v=1 d=10 s=0",
               out_valid, out_data, out_sel);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap_gaps();
    logic [WIDTH-1:0] exp_d [3];
    int               exp_s [3];
    logic [NCH-1:0]   vpat  [3];
    mode = 1'b0; out_ready = 1'b1; set_data(8'hC0);
    // Only ch2 valid: granted from any pointer, leaves ptr at 3.
    in_valid = 4'b0100;
    tick();
    vpat[0] = 4'b1001; exp_s[0] = 3; exp_d[0] = 8'hC3;
    vpat[1] = 4'b1001; exp_s[1] = 0; exp_d[1] = 8'hC0;
    vpat[2] = 4'b0000; exp_s[2] = 0; exp_d[2] = 8'hC0;
    for (int c = 0; c < 3; c++) begin
      in_valid = vpat[c];
      #1;
      n_checks++;
      if (in_ready !== exp_ready()) begin
        n_errors++; $display("FAIL wrap_ready cyc=%0d got %b exp %b", c, in_ready, exp_ready());
      end
      tick();
      n_checks++;
      if (out_valid !== (c < 2) || out_sel !== 2'(exp_s[c]) || out_data !== exp_d[c]) begin
        n_errors++;
        $display("FAIL wrap_out cyc=%0d got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
                 c, out_valid, out_sel, out_data, (c < 2), exp_s[c], exp_d[c]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    mode = 1'b0; out_ready = 1'b1; set_data(8'hE0);
    in_valid = 4'b0010;   // ch1 wins -> ptr=2
    tick();
    out_ready = 1'b0; in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
      n_errors++;
      $display("FAIL midrst_async got v=%b d=%h s=%0d r=%b exp v=0 d=00 s=0 r=0000",
               out_valid, out_data, out_sel, in_ready);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_errors++; $display("FAIL midrst_ready got %b exp 0001", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hE0) begin
      n_errors++;
      $display("FAIL midrst_first got v=%b s=%0d d=%h exp v=1 s=0 d=e0",
               out_valid, out_sel, out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      n_checks++;
      if ($countones(in_ready) > 1 || in_ready !== exp_ready()) begin
        n_errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", c, in_ready, exp_ready());
      end
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== 2'(m_sel)) begin
        n_errors++;
        $display("FAIL rand_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                 c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_wrap_gaps();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
